program_counter: RTL and testbench



---
 rtl/program_counter_pkg.sv | 11 +
 rtl/program_counter.sv | 27 ++
 tb/tb_program_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/program_counter_pkg.sv
// Shared core definitions: PC width, reset vector and PC type used by fetch,
// branch and PC-mux logic.
package program_counter_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/program_counter.sv
// Architectural PC register at the head of fetch: captures the upstream next-PC
// every cycle, async active-high reset to the reset vector.
module program_counter #(
  parameter int unsigned        XLEN         = program_counter_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_VECTOR = program_counter_pkg::RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next
);

  import program_counter_pkg::*;

  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= pc_in;
    end
  end

  assign pc_next = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed plan followed by random
// traffic, with async-reset and between-edge checks.
module tb_program_counter;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_next;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [XLEN-1:0] expq[$];
  logic [XLEN-1:0] last_exp;

  program_counter #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_in   (pc_in),
    .pc_next (pc_next)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    n_tests++;
    if ($isunknown(act) || act !== req) begin
      n_fail++;
      $display("FAIL %s: pc_next=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) check("edge", pc_next, expq.pop_front());
    end
  end

  // Drive one cycle's inputs shortly after the falling edge; the model says
  // the register holds RV under reset and otherwise pc_in after one edge.
  task automatic cycle(input logic r, input logic [XLEN-1:0] p);
    @(negedge clk);
    #1;
    rst   = r;
    pc_in = p;
    last_exp = r ? RV : p;
    expq.push_back(last_exp);
  endtask

  // Change pc_in between edges: output must still show the previous value.
  task automatic mid_change(input logic [XLEN-1:0] p);
    logic [XLEN-1:0] held;
    held = expq.size() > 0 ? pc_next : last_exp;
    #1;
    held = pc_next;
    pc_in = p;
    #1;
    check("between_edge_hold", pc_next, held);
    if (!rst) begin
      last_exp = p;
      expq[expq.size()-1] = p;
    end
  endtask

  // Assert reset between edges: output must drop to RV without a clock edge.
  task automatic mid_reset();
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", pc_next, RV);
    last_exp = RV;
    expq[expq.size()-1] = RV;
  endtask

  initial begin
    logic [XLEN-1:0] p;
    rst      = 1'b1;
    pc_in    = 32'h4;
    last_exp = RV;
    #1;
    check("reset_initial", pc_next, RV);

    cycle(1'b1, 32'h4);
    cycle(1'b1, 32'h4);
    cycle(1'b0, 32'h4);
    cycle(1'b0, 32'h8);
    cycle(1'b0, 32'hC);
    cycle(1'b0, 32'h1234_5678);
    mid_reset();
    cycle(1'b1, 32'h1234_5678);
    cycle(1'b1, 32'h1234_5678);
    cycle(1'b0, 32'hFFFF_FFFC);
    cycle(1'b0, 32'hABCD_1234);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h100);
    cycle(1'b0, 32'h100);
    mid_change(32'h200);
    cycle(1'b0, 32'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      p = $urandom;
      cycle(($urandom_range(0, 15) == 0), p);
      case ($urandom_range(0, 9))
        0: mid_reset();
        1: mid_change($urandom);
        default: ;
      endcase
    end

    cycle(1'b0, 32'h0000_0040);
    repeat (3) @(negedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d required=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
